// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync, active flag, line/frame strobes, RGB blanking.
// Define VGA_FRAME_CTR_EN to add the frame_count output.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 100,
  parameter int H_FP      = 7,
  parameter int H_SYNC    = 15,
  parameter int H_BP      = 8,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int FRAME_W   = 8,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_ce,
  input  logic [2:0]    rgb_in,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
`ifdef VGA_FRAME_CTR_EN
  output logic [FRAME_W-1:0] frame_count,
`endif
  output logic [2:0]    rgb_out
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || FRAME_W < 1) begin : g_param_check
    $error("vga_timing_gen: active, porch, sync and frame widths must all be nonzero");
  end

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic          h_wrap, v_wrap;
  logic [HW-1:0] hcount_p0;
  logic [VW-1:0] vcount_p0;
  logic          hsync_p0, vsync_p0, active_p0;

  // Stage p0: next counter values and decodes from them, so registered outputs share one edge.
  always_comb begin
    h_wrap    = (hcount == H_LAST);
    v_wrap    = (vcount == V_LAST);
    hcount_p0 = h_wrap ? '0 : hcount + HW'(1);
    vcount_p0 = vcount;
    if (h_wrap) begin
      vcount_p0 = v_wrap ? '0 : vcount + VW'(1);
    end
    hsync_p0  = ((hcount_p0 >= HS_BEGIN) && (hcount_p0 < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_p0  = ((vcount_p0 >= VS_BEGIN) && (vcount_p0 < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    active_p0 = (hcount_p0 < H_ACT_END) && (vcount_p0 < V_ACT_END);
  end

  // Stage p1: registered raster state; strobes only live for the clock after an advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      active      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      hcount      <= hcount_p0;
      vcount      <= vcount_p0;
      hsync       <= hsync_p0;
      vsync       <= vsync_p0;
      active      <= active_p0;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CTR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (pix_ce && h_wrap && v_wrap) begin
      frame_count <= frame_count + FRAME_W'(1);
    end
  end
`endif

  assign rgb_out = rgb_in & {3{active}};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: reset table, scoreboard of a raster model over three parameter sets, corner sequences.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pix_ce;
  logic [2:0] rgb_in;

  logic [7:0] hc_a; logic [9:0] vc_a; logic hs_a, vs_a, act_a, ls_a, fs_a; logic [2:0] rgb_a;
  logic [7:0] hc_b; logic [3:0] vc_b; logic hs_b, vs_b, act_b, ls_b, fs_b; logic [2:0] rgb_b;
  logic [3:0] hc_c; logic [2:0] vc_c; logic hs_c, vs_c, act_c, ls_c, fs_c; logic [2:0] rgb_c;
`ifdef VGA_FRAME_CTR_EN
  logic [7:0] fc_a, fc_b; logic [1:0] fc_c;
`endif

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .rgb_in(rgb_in),
    .hcount(hc_a), .vcount(vc_a), .hsync(hs_a), .vsync(vs_a), .active(act_a),
    .line_start(ls_a), .frame_start(fs_a),
`ifdef VGA_FRAME_CTR_EN
    .frame_count(fc_a),
`endif
    .rgb_out(rgb_a));

  vga_timing_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .rgb_in(rgb_in),
    .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b), .active(act_b),
    .line_start(ls_b), .frame_start(fs_b),
`ifdef VGA_FRAME_CTR_EN
    .frame_count(fc_b),
`endif
    .rgb_out(rgb_b));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FRAME_W(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .rgb_in(rgb_in),
    .hcount(hc_c), .vcount(vc_c), .hsync(hs_c), .vsync(vs_c), .active(act_c),
    .line_start(ls_c), .frame_start(fs_c),
`ifdef VGA_FRAME_CTR_EN
    .frame_count(fc_c),
`endif
    .rgb_out(rgb_c));

  // Raster model configuration, one column per DUT instance.
  int ha[3]  = '{100, 100, 8};
  int hf[3]  = '{7, 7, 1};
  int hsw[3] = '{15, 15, 2};
  int hb[3]  = '{8, 8, 1};
  int va[3]  = '{600, 4, 2};
  int vf[3]  = '{37, 2, 1};
  int vsw[3] = '{6, 2, 1};
  int vb[3]  = '{23, 2, 1};
  bit hp[3]  = '{1'b0, 1'b0, 1'b1};
  bit vp[3]  = '{1'b0, 1'b0, 1'b1};
  int fcmod[3] = '{256, 256, 4};

  int   mh[3], mv[3], mfc[3];
  logic mls[3], mfs[3];

  typedef struct {
    int h; int v;
    logic hs; logic vs; logic act; logic ls; logic fs;
    logic [2:0] rgb;
    int fc;
  } rec_t;

  rec_t sbq[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  function automatic void reset_model();
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0; mv[i] = 0; mfc[i] = 0; mls[i] = 1'b0; mfs[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(int id, logic ce);
    int ht = ha[id] + hf[id] + hsw[id] + hb[id];
    int vt = va[id] + vf[id] + vsw[id] + vb[id];
    mls[id] = 1'b0;
    mfs[id] = 1'b0;
    if (ce) begin
      if (mh[id] == ht - 1) begin
        mh[id] = 0;
        mls[id] = 1'b1;
        if (mv[id] == vt - 1) begin
          mv[id] = 0;
          mfs[id] = 1'b1;
          mfc[id] = (mfc[id] + 1) % fcmod[id];
        end else begin
          mv[id] = mv[id] + 1;
        end
      end else begin
        mh[id] = mh[id] + 1;
      end
    end
  endfunction

  function automatic rec_t expect_of(int id, logic [2:0] rgb);
    rec_t r;
    int hsb = ha[id] + hf[id];
    int vsb = va[id] + vf[id];
    r.h   = mh[id];
    r.v   = mv[id];
    r.hs  = (mh[id] >= hsb && mh[id] < hsb + hsw[id]) ? hp[id] : !hp[id];
    r.vs  = (mv[id] >= vsb && mv[id] < vsb + vsw[id]) ? vp[id] : !vp[id];
    r.act = (mh[id] < ha[id]) && (mv[id] < va[id]);
    r.ls  = mls[id];
    r.fs  = mfs[id];
    r.rgb = r.act ? rgb : 3'b000;
    r.fc  = mfc[id];
    return r;
  endfunction

  function automatic rec_t actual_of(int id);
    rec_t r;
    r.fc = 0;
    case (id)
      0: begin
        r.h = int'(hc_a); r.v = int'(vc_a); r.hs = hs_a; r.vs = vs_a;
        r.act = act_a; r.ls = ls_a; r.fs = fs_a; r.rgb = rgb_a;
`ifdef VGA_FRAME_CTR_EN
        r.fc = int'(fc_a);
`endif
      end
      1: begin
        r.h = int'(hc_b); r.v = int'(vc_b); r.hs = hs_b; r.vs = vs_b;
        r.act = act_b; r.ls = ls_b; r.fs = fs_b; r.rgb = rgb_b;
`ifdef VGA_FRAME_CTR_EN
        r.fc = int'(fc_b);
`endif
      end
      default: begin
        r.h = int'(hc_c); r.v = int'(vc_c); r.hs = hs_c; r.vs = vs_c;
        r.act = act_c; r.ls = ls_c; r.fs = fs_c; r.rgb = rgb_c;
`ifdef VGA_FRAME_CTR_EN
        r.fc = int'(fc_c);
`endif
      end
    endcase
    return r;
  endfunction

  task automatic compare(int id, rec_t e, rec_t a);
    bit bad;
    vectors++;
    bad = (a.h != e.h) || (a.v != e.v) || (a.hs !== e.hs) || (a.vs !== e.vs) ||
          (a.act !== e.act) || (a.ls !== e.ls) || (a.fs !== e.fs) || (a.rgb !== e.rgb);
`ifdef VGA_FRAME_CTR_EN
    if (a.fc != e.fc) bad = 1'b1;
`endif
    if (bad) begin
      miscompares++;
      $display("FAIL sb_dut%0d cyc %0d: got h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b rgb=%b fc=%0d, want h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b rgb=%b fc=%0d",
               id, cyc_n, a.h, a.v, a.hs, a.vs, a.act, a.ls, a.fs, a.rgb, a.fc,
               e.h, e.v, e.hs, e.vs, e.act, e.ls, e.fs, e.rgb, e.fc);
    end
  endtask

  task automatic chk(string nm, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Called at a negedge: drive, push expectations, sample after the posedge, return at the next negedge.
  task automatic cyc(logic ce, logic [2:0] rgb);
    pix_ce = ce;
    rgb_in = rgb;
    for (int i = 0; i < 3; i++) begin
      model_step(i, ce);
      sbq.push_back(expect_of(i, rgb));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rec_t e = sbq.pop_front();
      compare(i, e, actual_of(i));
    end
    cyc_n++;
    @(negedge clk);
  endtask

  typedef struct {
    logic ce; logic [2:0] rgb; int h; logic ls; logic [2:0] rgb_o;
  } vec_t;
  vec_t tbl[8];

  int lo_n, lo_min, lo_max, act_off, lit_n, first_ls_h, first_ls_v;
  int fs_b_n, vs_b_lo, hmask, last_ls_c, per_c, per_bad;
  int fsb_t0, fsb_t1, last_ls_a, per_a, ls_wide;
  logic ls_prev;
  int fcs[$];
  bit found;

  initial begin
    tbl[0] = '{1'b1, 3'b111, 1, 1'b0, 3'b111};
    tbl[1] = '{1'b0, 3'b010, 1, 1'b0, 3'b010};
    tbl[2] = '{1'b1, 3'b100, 2, 1'b0, 3'b100};
    tbl[3] = '{1'b1, 3'b001, 3, 1'b0, 3'b001};
    tbl[4] = '{1'b0, 3'b110, 3, 1'b0, 3'b110};
    tbl[5] = '{1'b0, 3'b011, 3, 1'b0, 3'b011};
    tbl[6] = '{1'b1, 3'b110, 4, 1'b0, 3'b110};
    tbl[7] = '{1'b1, 3'b011, 5, 1'b0, 3'b011};

    reset_n = 1'b0;
    pix_ce  = 1'b1;
    rgb_in  = 3'b101;
    reset_model();
    repeat (5) @(posedge clk);
    #1;
    chk("rst_hcount", int'(hc_a), 0);
    chk("rst_vcount", int'(vc_a), 0);
    chk("rst_active", int'(act_a), 1);
    chk("rst_hsync", int'(hs_a), 1);
    chk("rst_vsync", int'(vs_a), 1);
    chk("rst_strobes", int'({ls_a, fs_a}), 0);
    chk("rst_rgb", int'(rgb_a), 5);
    chk("rst_hsync_pol1", int'(hs_c), 0);
`ifdef VGA_FRAME_CTR_EN
    chk("rst_frame_count", int'(fc_c), 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].ce, tbl[i].rgb);
      chk($sformatf("tbl%0d_hcount", i), int'(hc_a), tbl[i].h);
      chk($sformatf("tbl%0d_vcount", i), int'(vc_a), 0);
      chk($sformatf("tbl%0d_line_start", i), int'(ls_a), int'(tbl[i].ls));
      chk($sformatf("tbl%0d_rgb_out", i), int'(rgb_a), int'(tbl[i].rgb_o));
    end

    // Full-rate run: horizontal decode, blanking, small-frame wrap, polarity instance.
    lo_n = 0; lo_min = 999; lo_max = -1; act_off = 999; lit_n = 0;
    first_ls_h = -1; first_ls_v = -1;
    fs_b_n = 0; vs_b_lo = 0; hmask = 0; last_ls_c = -1; per_c = -1; per_bad = 0;
    for (int k = 0; k < 2700; k++) begin
      cyc(1'b1, 3'b111);
      if (vc_a == 10'd1) begin
        if (!hs_a) begin
          lo_n++;
          if (int'(hc_a) < lo_min) lo_min = int'(hc_a);
          if (int'(hc_a) > lo_max) lo_max = int'(hc_a);
        end
        if (!act_a && int'(hc_a) < act_off) act_off = int'(hc_a);
        if (rgb_a == 3'b111) lit_n++;
      end
      if (ls_a && first_ls_v < 0) begin
        first_ls_h = int'(hc_a);
        first_ls_v = int'(vc_a);
      end
      if (fs_b) fs_b_n++;
      if (fs_b_n == 0 && !vs_b) vs_b_lo++;
      if (hs_c) hmask = hmask | (1 << hc_c);
      if (ls_c) begin
        if (last_ls_c >= 0) begin
          per_c = k - last_ls_c;
          if (per_c != 12) per_bad++;
        end
        last_ls_c = k;
      end
`ifdef VGA_FRAME_CTR_EN
      if (fs_c && fcs.size() < 5) fcs.push_back(int'(fc_c));
`endif
    end
    chk("hsync_low_count", lo_n, 15);
    chk("hsync_first_px", lo_min, 107);
    chk("hsync_last_px", lo_max, 121);
    chk("active_off_px", act_off, 100);
    chk("lit_pixels_line1", lit_n, 100);
    chk("first_line_start_h", first_ls_h, 0);
    chk("first_line_start_v", first_ls_v, 1);
    chk("frame_wraps_b", fs_b_n, 2);
    chk("vsync_low_advances_b", vs_b_lo, 260);
    chk("hsync_pol1_pixels", hmask, 'h600);
    chk("line_period_c", per_c, 12);
    chk("line_period_c_bad", per_bad, 0);
`ifdef VGA_FRAME_CTR_EN
    chk("frame_count_n", fcs.size(), 5);
    if (fcs.size() == 5) begin
      chk("frame_count_0", fcs[0], 1);
      chk("frame_count_1", fcs[1], 2);
      chk("frame_count_2", fcs[2], 3);
      chk("frame_count_3", fcs[3], 0);
      chk("frame_count_4", fcs[4], 1);
    end
`endif

    // Pixel enable at one clock in four.
    fsb_t0 = -1; fsb_t1 = -1; last_ls_a = -1; per_a = -1; ls_wide = 0; ls_prev = 1'b0;
    for (int k = 0; k < 10500; k++) begin
      cyc((k % 4) == 0, 3'($urandom_range(0, 7)));
      if (fs_b) begin
        if (fsb_t0 < 0) fsb_t0 = k;
        else if (fsb_t1 < 0) fsb_t1 = k;
      end
      if (ls_a) begin
        if (last_ls_a >= 0 && per_a < 0) per_a = k - last_ls_a;
        last_ls_a = k;
      end
      if (ls_a && ls_prev) ls_wide++;
      ls_prev = ls_a;
    end
    chk("frame_period_ce4", fsb_t1 - fsb_t0, 5200);
    chk("line_period_ce4", per_a, 520);
    chk("line_start_wide", ls_wide, 0);

    for (int k = 0; k < 300; k++) begin
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    // Reset asserted on the clock a line_start is high.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(1'b1, 3'b111);
      if (ls_c) found = 1'b1;
    end
    chk("found_line_start_c", int'(found), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_hcount_c", int'(hc_c), 0);
    chk("midrst_vcount_c", int'(vc_c), 0);
    chk("midrst_hsync_c", int'(hs_c), 0);
    chk("midrst_vsync_c", int'(vs_c), 0);
    chk("midrst_active_c", int'(act_c), 1);
    chk("midrst_line_start_c", int'(ls_c), 0);
    chk("midrst_hcount_a", int'(hc_a), 0);
    chk("midrst_hsync_a", int'(hs_a), 1);
    @(negedge clk);
    reset_n = 1'b1;
    reset_model();
    for (int k = 0; k < 30; k++) begin
      cyc(1'b1, 3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator for the Tetris video path. It produces pixel/scanline counters, sync pulses with configurable polarity, an active-video flag, and line/frame start strobes, all advanced by a pixel clock-enable so that one system clock serves any pixel rate. It also gates the game's RGB to black outside active video. Game and Memory read addresses derive from hcount/vcount.

Parameters:
H_ACTIVE, 100, visible pixels per line
H_FP, 7, horizontal front porch (pixels)
H_SYNC, 15, hsync width (pixels)
H_BP, 8, horizontal back porch (pixels); H_TOTAL = sum = 130
V_ACTIVE, 600, visible lines
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vsync width (lines)
V_BP, 23, vertical back porch (lines); V_TOTAL = sum = 666
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync
FRAME_W, 8, frame counter width (optional feature only)

Ports:
clk  in  1  system clock; all state changes on posedge
reset_n  in  1  asynchronous, active-low reset
pix_ce  in  1  pixel advance enable; counters move only when high
hcount  out  HW=$clog2(H_TOTAL)  current pixel index 0..H_TOTAL-1
vcount  out  VW=$clog2(V_TOTAL)  current line index 0..V_TOTAL-1
hsync  out  1  horizontal sync at HSYNC_POL when asserted
vsync  out  1  vertical sync at VSYNC_POL when asserted
active  out  1  high iff hcount<H_ACTIVE and vcount<V_ACTIVE
line_start  out  1  one-clk pulse when hcount advances to 0
frame_start  out  1  one-clk pulse when (hcount,vcount) advances to (0,0)
rgb_in  in  3  {r,g,b} from the game
rgb_out  out  3  rgb_in & {3{active}}, combinational
frame_count  out  FRAME_W  frames completed (VGA_FRAME_CTR_EN only)

Behaviour:
- Reset (async, reset_n=0): hcount=0, vcount=0, active=1, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=0, frame_start=0, frame_count=0. No strobe on reset release.
- On a posedge with pix_ce=1: hcount=H_TOTAL-1 -> hcount=0 and vcount increments; vcount=V_TOTAL-1 at that point -> vcount=0. Otherwise hcount increments.
- pix_ce=0: all counters and decodes hold; line_start/frame_start clear to 0.
- hsync, vsync, and active are registered. They are decoded from the next counter values, so they are cycle-aligned with hcount/vcount (zero skew, glitch-free).
- hsync is asserted iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC. vsync uses the same form with V_*. Defaults give hsync on pixels 107..121 and vsync on lines 637..642.
- line_start = 1 for exactly one clk after the advance that lands hcount at 0, including the frame wrap. frame_start is the same, only for the (0,0) wrap. Both are 0 in every other cycle, including stalled pix_ce cycles.
- Sync timing is in pixels/lines and is independent of pix_ce duty cycle.
- Elaboration check: $error if any porch/sync parameter is 0 or H_ACTIVE/V_ACTIVE is 0.
- Reset asserted mid-line or mid-sync returns all outputs to their reset values immediately, with no partial pulses afterward.

Optional Feature:
VGA_FRAME_CTR_EN
- Defined: the frame_count port exists. It increments by 1 on each frame_start pulse, wraps modulo 2^FRAME_W, and resets to 0. It is used for gravity timing and blink effects.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 with pix_ce=1 for 5 clk -> hcount=0, vcount=0, active=1, hsync=1, vsync=1, rgb_out=rgb_in; release -> hcount=1 after one edge, no line_start/frame_start.
- Horizontal timing (defaults, pix_ce=1): hsync=0 exactly for hcount 107..121 (15 clk); active=0 from hcount 100; at hcount 129 -> next edge gives hcount=0, vcount=1, line_start=1 for one clk.
- Frame wrap: run to vcount=665, hcount=129 -> next edge gives (0,0), frame_start=1 and line_start=1 for one clk; vsync=0 exactly for lines 637..642 (6×130 pixel-advances).
- Clock enable: pix_ce high 1 in 4 clk -> counters step every 4th clk; line_start width remains 1 clk; a full frame takes 4×130×666 clk.
- Blanking: rgb_in=3'b111 constant -> rgb_out=3'b111 only when hcount<100 and vcount<600, else 3'b000.
- Feature and parameters: with VGA_FRAME_CTR_EN and FRAME_W=2, run 5 frames -> frame_count sequence 1,2,3,0,1. With HSYNC_POL=1 and H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1 -> hsync=1 exactly at hcount 9,10, and the line period is 12.
